// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host receive deserializer. Synchronizes the
//                raw PS/2 clock and data pins into the system clock domain,
//                glitch-filters the PS/2 clock, detects its falling edges and
//                shifts in 11-bit frames (start, 8 data LSB-first, odd
//                parity, stop). Each frame ends in either a one-cycle
//                rx_valid strobe with the byte on rx_data, or a one-cycle
//                rx_error strobe (framing, parity or inter-bit timeout).
//  Ports       : clk      - system clock, the only clock
//                rst      - synchronous active-high reset
//                ps2_clk  - raw PS/2 clock pin (asynchronous)
//                ps2_data - raw PS/2 data pin (asynchronous)
//                rx_data  - last correctly received byte
//                rx_valid - one-cycle pulse when rx_data is updated
//                rx_error - one-cycle pulse on a rejected frame
//                busy     - high while a frame is being received
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 65_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_error,
   output logic       busy
);

   localparam int              c_tmo_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      c_stop_idx = 4'd9;
   localparam logic [3:0]      c_par_idx  = 4'd8;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Input synchronizers (reset to 1: idle bus is high)
   // ------------------------------------------------------------------------
   logic [1:0] r_sync_clk;
   logic [1:0] r_sync_data;
   logic       w_clk_s;
   logic       w_data_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_clk  <= 2'b11;
         r_sync_data <= 2'b11;
      end else begin
         r_sync_clk  <= {r_sync_clk[0], ps2_clk};
         r_sync_data <= {r_sync_data[0], ps2_data};
      end
   end

   assign w_clk_s  = r_sync_clk[1];
   assign w_data_s = r_sync_data[1];

   // ------------------------------------------------------------------------
   // Clock glitch filter. The decision looks at the register contents
   // including the sample being shifted in this cycle, so FILTER_LEN
   // consecutive identical samples are enough to flip the filtered clock.
   // ------------------------------------------------------------------------
   logic [FILTER_LEN-1:0] r_filt;
   logic [FILTER_LEN-1:0] w_filt_next;
   logic                  r_fclk;
   logic                  r_fclk_d;
   logic                  w_fall;

   generate
      if (FILTER_LEN > 1) begin : g_filt_shift
         assign w_filt_next = {r_filt[FILTER_LEN-2:0], w_clk_s};
      end else begin : g_filt_single
         assign w_filt_next = w_clk_s;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt   <= '1;
         r_fclk   <= 1'b1;
         r_fclk_d <= 1'b1;
      end else begin
         r_filt   <= w_filt_next;
         if (~|w_filt_next) begin
            r_fclk <= 1'b0;
         end else if (&w_filt_next) begin
            r_fclk <= 1'b1;
         end
         r_fclk_d <= r_fclk;
      end
   end

   assign w_fall = ~r_fclk & r_fclk_d;

   // ------------------------------------------------------------------------
   // Frame FSM and datapath
   // ------------------------------------------------------------------------
   state_t               r_state;
   state_t               w_state_next;
   logic [3:0]           r_bit_cnt;
   logic [7:0]           r_shift;
   logic                 r_parity;
   logic [c_tmo_w-1:0]   r_tmo_cnt;
   logic [c_tmo_w-1:0]   w_tmo_inc;
   logic [7:0]           r_rx_data;
   logic                 r_rx_valid;
   logic                 r_rx_error;
   logic                 w_start;
   logic                 w_valid_next;
   logic                 w_error_next;
   logic                 w_frame_ok;

   assign w_tmo_inc  = r_tmo_cnt + 1'b1;
   // Odd parity over data+parity, and the bit currently sampled is the stop.
   assign w_frame_ok = (^{r_shift, r_parity}) & w_data_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_valid_next = 1'b0;
      w_error_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A high bit on a fall while idle is simply ignored.
            if (w_fall && !w_data_s) begin
               w_state_next = S_RECV;
               w_start      = 1'b1;
            end
         end
         S_RECV: begin
            // A fall takes priority over a coincident timeout.
            if (w_fall) begin
               if (r_bit_cnt >= c_stop_idx) begin
                  w_state_next = S_IDLE;
                  w_valid_next = w_frame_ok;
                  w_error_next = ~w_frame_ok;
               end
            end else if (w_tmo_inc == c_tmo_last) begin
               w_state_next = S_IDLE;
               w_error_next = 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt  <= 4'd0;
         r_shift    <= 8'h00;
         r_parity   <= 1'b0;
         r_tmo_cnt  <= '0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_rx_error <= 1'b0;
      end else begin
         r_rx_valid <= w_valid_next;
         r_rx_error <= w_error_next;
         if (w_valid_next) begin
            r_rx_data <= r_shift;
         end

         if (w_start) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_tmo_cnt <= '0;
         end else if (r_state == S_RECV) begin
            if (w_fall) begin
               r_tmo_cnt <= '0;
               r_bit_cnt <= r_bit_cnt + 4'd1;
               if (r_bit_cnt < c_par_idx) begin
                  // Insert at MSB and shift right: first bit ends at bit 0.
                  r_shift <= {w_data_s, r_shift[7:1]};
               end else if (r_bit_cnt == c_par_idx) begin
                  r_parity <= w_data_s;
               end
            end else begin
               r_tmo_cnt <= w_tmo_inc;
            end
         end else begin
            r_tmo_cnt <= '0;
         end
      end
   end

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign rx_error = r_rx_error;
   assign busy     = (r_state == S_RECV);

endmodule
`default_nettype wire
